// File: rtl/gemm_tile_engine_if.sv
// Command, status and memory-port bundle of the GEMM tile engine.
// The engine masters the A/B/C memory ports; the host/memory side is the slave.
interface gemm_tile_engine_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 16
);
  logic                          start, abort, acc_mode;
  logic [1:0]                    prec;
  logic [15:0]                   M, K, N;
  logic                          busy, done, err;
  logic                          a_en;
  logic [ADDR_W-1:0]             a_addr;
  logic [DATA_W-1:0]             a_rdata;
  logic                          b_en;
  logic [ADDR_W-1:0]             b_addr;
  logic [LANES-1:0][DATA_W-1:0]  b_rdata;
  logic                          c_rd_en;
  logic [ADDR_W-1:0]             c_addr;
  logic [LANES-1:0][ACC_W-1:0]   c_rdata;
  logic [LANES-1:0]              c_we;
  logic [LANES-1:0][ACC_W-1:0]   c_wdata;

  modport master (
    input  start, abort, acc_mode, prec, M, K, N, a_rdata, b_rdata, c_rdata,
    output busy, done, err, a_en, a_addr, b_en, b_addr, c_rd_en, c_addr, c_we, c_wdata
  );
  modport slave (
    output start, abort, acc_mode, prec, M, K, N, a_rdata, b_rdata, c_rdata,
    input  busy, done, err, a_en, a_addr, b_en, b_addr, c_rd_en, c_addr, c_we, c_wdata
  );
endinterface

// File: rtl/gemm_tile_engine.sv
// Tiled integer GEMM: computes LANES output columns of C per pass, with a
// read / operand-register / multiply-accumulate pipeline over the K dimension.
module gemm_lane #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        prec,
  input  logic              cap,
  input  logic              mac,
  input  logic              ld,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_op,
  input  logic [DATA_W-1:0] b_word,
  input  logic [ACC_W-1:0]  c_word,
  output logic [ACC_W-1:0]  acc
);
  logic [DATA_W-1:0]            b_op;
  logic signed [2*DATA_W-1:0]   prod;

  function automatic logic signed [2*DATA_W-1:0] sext(input logic [DATA_W-1:0] w,
                                                       input logic [1:0] p);
    case (p)
      2'b00:   sext = (2*DATA_W)'($signed(w[7:0]));
      2'b01:   sext = (2*DATA_W)'($signed(w[15:0]));
      default: sext = (2*DATA_W)'($signed(w));
    endcase
  endfunction

  assign prod = sext(a_op, prec) * sext(b_op, prec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_op <= '0;
      acc  <= '0;
    end else begin
      if (cap) b_op <= b_word;
      if (ld)        acc <= c_word;
      else if (clr)  acc <= '0;
      else if (mac)  acc <= acc + ACC_W'(prod);
    end
  end
endmodule

module gemm_tile_engine #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 16
) (
  input logic clk,
  input logic rst,
  gemm_tile_engine_if.master bus
);
  typedef enum logic [2:0] {IDLE, CHECK, LOADC, MAC, DRAIN, WRITE, DONE} state_t;
  typedef struct packed {
    logic        acc_mode;
    logic [1:0]  prec;
    logic [15:0] m, k, n;
  } cfg_t;

  state_t                      state, nxt;
  cfg_t                        cfg;
  logic [15:0]                 i, j, k;
  logic                        lph, err_r;
  logic [1:0]                  vld_pipe;
  logic [DATA_W-1:0]           a_op;
  logic [LANES-1:0][ACC_W-1:0] acc;
  logic [16:0]                 j_nxt;
  logic                        row_end, last_pass, k_last, bad_cfg;

  assign j_nxt     = {1'b0, j} + 17'(LANES);
  assign row_end   = j_nxt >= {1'b0, cfg.n};
  assign last_pass = row_end && (({1'b0, i} + 17'd1) == {1'b0, cfg.m});
  assign k_last    = ({1'b0, k} + 17'd1) == {1'b0, cfg.k};
  assign bad_cfg   = (cfg.m == '0) || (cfg.k == '0) || (cfg.n == '0) || (cfg.prec == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (bus.start) nxt = CHECK;
      CHECK: nxt = bad_cfg ? DONE : (cfg.acc_mode ? LOADC : MAC);
      LOADC: if (lph) nxt = MAC;
      MAC:   if (k_last) nxt = DRAIN;
      DRAIN: if (!vld_pipe[0]) nxt = WRITE;
      WRITE: nxt = last_pass ? DONE : (cfg.acc_mode ? LOADC : MAC);
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // a WRITE cycle still drives its strobes; abort only redirects what follows
    if (bus.abort && state != IDLE) nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg      <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      lph      <= 1'b0;
      err_r    <= 1'b0;
      vld_pipe <= '0;
      a_op     <= '0;
    end else begin
      vld_pipe <= bus.abort ? 2'b00 : {vld_pipe[0], state == MAC};
      if (vld_pipe[0]) a_op <= bus.a_rdata;
      case (state)
        IDLE:  if (bus.start) cfg <= '{bus.acc_mode, bus.prec, bus.M, bus.K, bus.N};
        CHECK: begin
          i <= '0; j <= '0; k <= '0; lph <= 1'b0;
          err_r <= bad_cfg;
        end
        LOADC: lph <= ~lph;
        MAC:   k <= k + 16'd1;
        WRITE: begin
          k <= '0;
          if (row_end) begin
            j <= '0;
            i <= i + 16'd1;
          end else begin
            j <= j_nxt[15:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE) && (state != DONE);
  assign bus.done    = (state == DONE);
  assign bus.err     = (state == DONE) && err_r;
  assign bus.a_en    = (state == MAC);
  assign bus.b_en    = (state == MAC);
  assign bus.c_rd_en = (state == LOADC) && !lph;
  assign bus.a_addr  = bus.a_en ? ADDR_W'(32'(i) * 32'(cfg.k) + 32'(k)) : '0;
  assign bus.b_addr  = bus.b_en ? ADDR_W'(32'(k) * 32'(cfg.n) + 32'(j)) : '0;
  assign bus.c_addr  = (bus.c_rd_en || state == WRITE) ?
                       ADDR_W'(32'(i) * 32'(cfg.n) + 32'(j)) : '0;
  assign bus.c_wdata = acc;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // lanes past the right edge of C are masked on the last pass of a row
    assign bus.c_we[l] = (state == WRITE) && (({1'b0, j} + 17'(l)) < {1'b0, cfg.n});

    gemm_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .prec   (cfg.prec),
      .cap    (vld_pipe[0]),
      .mac    (vld_pipe[1]),
      .ld     ((state == LOADC) && lph),
      .clr    ((state == MAC) && (k == '0) && !cfg.acc_mode),
      .a_op   (a_op),
      .b_word (bus.b_rdata[l]),
      .c_word (bus.c_rdata[l]),
      .acc    (acc[l])
    );
  end
endmodule

// File: tb/tb_gemm_tile_engine.sv
// Random and directed GEMM jobs checked against a plain-arithmetic matrix model,
// including latency, tail masking, error, abort and mid-job reset behaviour.
module tb_gemm_tile_engine;
  localparam int L = 4;
  localparam int MEM = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gemm_tile_engine_if #(.LANES(L), .DATA_W(32), .ACC_W(32), .ADDR_W(16)) bus();

  gemm_tile_engine #(.LANES(L), .DATA_W(32), .ACC_W(32), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] amem [MEM];
  logic [31:0] bmem [MEM];
  logic [31:0] cmem [MEM];
  logic [31:0] expc [MEM];
  int          wcnt [MEM];
  logic [L-1:0] last_we;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // memories: one-cycle read latency, junk whenever the port is idle
  always @(posedge clk) begin
    bus.a_rdata <= bus.a_en ? amem[int'(bus.a_addr) % MEM] : $urandom;
    for (int l = 0; l < L; l++) begin
      bus.b_rdata[l] <= bus.b_en    ? bmem[(int'(bus.b_addr) + l) % MEM] : $urandom;
      bus.c_rdata[l] <= bus.c_rd_en ? cmem[(int'(bus.c_addr) + l) % MEM] : $urandom;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance to the next falling edge and commit any C write seen there
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int l = 0; l < L; l++) begin
      if (bus.c_we[l]) begin
        int a;
        a = (int'(bus.c_addr) + l) % MEM;
        cmem[a] = bus.c_wdata[l];
        wcnt[a]++;
      end
    end
    if (|bus.c_we) last_we = bus.c_we;
  endtask

  function automatic longint sx(input logic [31:0] w, input int p);
    case (p)
      0:       return longint'($signed(w[7:0]));
      1:       return longint'($signed(w[15:0]));
      default: return longint'($signed(w));
    endcase
  endfunction

  function automatic bit cfg_bad(input int p, input int m, input int k, input int n);
    return (m == 0) || (k == 0) || (n == 0) || (p == 3);
  endfunction

  task automatic model(input int acc, input int p, input int m, input int k, input int n);
    for (int a = 0; a < MEM; a++) expc[a] = cmem[a];
    if (cfg_bad(p, m, k, n)) return;
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        longint s;
        s = acc ? longint'($signed(cmem[r*n + c])) : 0;
        for (int q = 0; q < k; q++) s += sx(amem[r*k + q], p) * sx(bmem[q*n + c], p);
        expc[r*n + c] = s[31:0];
      end
  endtask

  task automatic clear_wcnt();
    for (int a = 0; a < MEM; a++) wcnt[a] = 0;
  endtask

  task automatic fill_rand();
    for (int a = 0; a < MEM; a++) begin
      amem[a] = $urandom;
      bmem[a] = $urandom;
      cmem[a] = $urandom;
    end
  endtask

  task automatic kick(input int acc, input int p, input int m, input int k, input int n);
    bus.start    = 1'b1;
    bus.acc_mode = acc[0];
    bus.prec     = p[1:0];
    bus.M        = m[15:0];
    bus.K        = k[15:0];
    bus.N        = n[15:0];
  endtask

  task automatic run_job(input string tag, input int acc, input int p,
                         input int m, input int k, input int n);
    int c0, lat, exp_lat, nmis, wmis;
    bit e;
    e = cfg_bad(p, m, k, n);
    exp_lat = e ? 2 : 2 + m * ((n + L - 1) / L) * (k + 3 + 2*acc);
    model(acc, p, m, k, n);
    clear_wcnt();
    kick(acc, p, m, k, n);
    c0 = cyc;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy"}, bus.busy, 1);
    lat = -1;
    for (int t = 0; t < exp_lat + 20; t++) begin
      if (bus.done) begin
        lat = cyc - c0;
        break;
      end
      tick();
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, bus.err, e);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    tick();
    check({tag, "_done_pulse"}, bus.done, 0);
    nmis = 0;
    wmis = 0;
    for (int a = 0; a < MEM; a++) begin
      if (cmem[a] !== expc[a]) nmis++;
      if (wcnt[a] != ((!e && a < m*n) ? 1 : 0)) wmis++;
    end
    check({tag, "_cdata"}, nmis, 0);
    check({tag, "_wmap"}, wmis, 0);
  endtask

  initial begin
    int s;
    bus.start = 1'b0; bus.abort = 1'b0; bus.acc_mode = 1'b0;
    bus.prec = 2'b00; bus.M = '0; bus.K = '0; bus.N = '0;
    last_we = '0;
    fill_rand();
    clear_wcnt();
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_en", {bus.a_en, bus.b_en, bus.c_rd_en}, 0);
    check("rst_we", bus.c_we, 0);
    check("rst_addr", {bus.a_addr, bus.b_addr, bus.c_addr}, 0);
    check("rst_wdata", bus.c_wdata, 0);
    rst = 1'b0;
    tick();

    // worked 2x2 * 2x4 example, then the accumulating rerun
    for (int a = 0; a < MEM; a++) cmem[a] = 0;
    amem[0] = 1; amem[1] = 2; amem[2] = 3; amem[3] = 4;
    bmem[0] = 5; bmem[1] = 6; bmem[2] = 7; bmem[3] = 8;
    for (int a = 4; a < 8; a++) bmem[a] = 1;
    run_job("ex", 0, 0, 2, 2, 4);
    check("ex_c00", cmem[0], 7);
    check("ex_c13", cmem[7], 28);
    run_job("exacc", 1, 0, 2, 2, 4);
    check("exacc_c00", cmem[0], 14);
    check("exacc_c13", cmem[7], 56);

    fill_rand();
    run_job("tail", 0, 0, 2, 2, 5);
    check("tail_we", last_we, 4'b0001);

    amem[0] = 32'h0000_00FF;
    bmem[0] = 32'h0000_0002;
    run_job("int8", 0, 0, 1, 1, 1);
    check("int8_val", cmem[0], 32'hFFFF_FFFE);
    run_job("int16", 0, 1, 1, 1, 1);
    check("int16_val", cmem[0], 510);

    run_job("k0", 0, 0, 2, 0, 3);
    run_job("prec3", 1, 3, 2, 2, 3);

    // abort in the MAC phase of the second pass (row 1)
    fill_rand();
    clear_wcnt();
    kick(0, 0, 2, 3, 4);
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    s = 0;
    for (int t = 0; t < 20; t++) begin
      if (bus.done) s++;
      tick();
    end
    check("abort_nodone", s, 0);
    check("abort_row0", wcnt[0] + wcnt[1] + wcnt[2] + wcnt[3], 4);
    check("abort_row1", wcnt[4] + wcnt[5] + wcnt[6] + wcnt[7], 0);
    run_job("post_abort", 0, 2, 2, 3, 4);

    // asynchronous reset in the middle of a job
    fill_rand();
    kick(1, 1, 2, 2, 6);
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", bus.busy, 0);
    check("mrst_we", bus.c_we, 0);
    clear_wcnt();
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    s = 0;
    for (int a = 0; a < MEM; a++) s += wcnt[a];
    check("mrst_nowrite", s, 0);
    run_job("post_rst", 1, 1, 2, 2, 6);

    for (int r = 0; r < 10; r++) begin
      fill_rand();
      run_job($sformatf("rnd%0d", r), $urandom_range(0, 1), $urandom_range(0, 2),
              $urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(1, 9));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gemm_tile_engine.md
GEMM_TILE_ENGINE -- requirements
Module: gemm_tile_engine

Interface
REQ-001 Parameter LANES, default 4: output columns computed in parallel per pass.
REQ-002 Parameter DATA_W, default 32: A/B element word width; operands use the low bits selected by prec.
REQ-003 Parameter ACC_W, default 32: accumulator and C element width.
REQ-004 Parameter ADDR_W, default 16: word address width of all memory ports.
REQ-005 Ports clk (in, 1, sole clock) and rst (in, 1, asynchronous active-high reset) come first; one clock, asynchronous active-high reset.
REQ-006 start in 1: request a GEMM; sampled only in IDLE.
REQ-007 abort in 1: cancel the running job.
REQ-008 acc_mode in 1: 1 = C += A*B, 0 = C = A*B; latched at start.
REQ-009 prec in 2: 00 signed INT8, 01 signed INT16, 10 signed INT32, 11 reserved (err); latched at start.
REQ-010 M, K, N in 16 each: row count of A, shared dimension, column count of B; latched at start.
REQ-011 busy out 1; done out 1 (one-cycle pulse); err out 1 (valid with done).
REQ-012 a_en out 1, a_addr out ADDR_W, a_rdata in DATA_W: A read port, row-major, address i*K+k.
REQ-013 b_en out 1, b_addr out ADDR_W, b_rdata in LANES*DATA_W: B read port, row-major; returns elements at b_addr+0..LANES-1 in lane order.
REQ-014 c_rd_en out 1, c_addr out ADDR_W, c_rdata in LANES*ACC_W: C read port, same lane layout.
REQ-015 c_we out LANES (per-lane write strobe), c_wdata out LANES*ACC_W: C write port sharing c_addr, base address i*N+j.

Function
REQ-016 All memory reads have exactly 1-cycle latency: data presented the cycle after the enable.
REQ-017 FSM states: IDLE, CHECK, LOADC, MAC, DRAIN, WRITE, DONE.
REQ-018 IDLE with start=1: latch the inputs and go to CHECK; busy rises the next cycle.
REQ-019 CHECK, with M==0, N==0, K==0 or prec==11: go to DONE with err=1 and perform no writes.
REQ-020 CHECK, otherwise: set i=0, j=0, err=0, then go to LOADC if acc_mode=1, else MAC.
REQ-021 LOADC: issue one C read at i*N+j and load the LANES accumulators from c_rdata; in MAC, accumulators are cleared instead when acc_mode=0.
REQ-022 MAC: issue one A read and one B read per cycle, k = 0..K-1, with no bubbles.
REQ-023 MAC operands: sign-extend the prec-selected low bits, form a full-width product, add it to the accumulator, truncate modulo 2^ACC_W (wrap, no saturation).
REQ-024 MAC pipeline: read (t), operand register (t+1), product plus accumulate (t+2); DRAIN waits for the last accumulate.
REQ-025 Pass latency from MAC entry to WRITE: K+2 cycles, plus 2 when acc_mode=1.
REQ-026 WRITE: one cycle, c_we[l]=1 only for lanes with j+l < N; tail lanes stay masked.
REQ-027 After WRITE: j += LANES; if j >= N then j=0 and i++; if i == M go to DONE, else go to LOADC/MAC.
REQ-028 DONE: done=1 for one cycle, busy=0 from the same cycle, then IDLE.
REQ-029 start while busy is ignored.
REQ-030 abort in any non-IDLE state: go to IDLE next cycle, no further c_we, no done pulse, busy=0.
REQ-031 abort and a WRITE cycle coinciding: the write completes; abort takes effect after it.
REQ-032 Address arithmetic wraps modulo 2^ADDR_W; no range error is flagged.
REQ-033 Total cycles start→done = 2 + M*ceil(N/LANES)*(passlatency+1).

Reset
REQ-034 rst=1 asynchronously forces IDLE; busy, done, err, a_en, b_en, c_rd_en, c_we and all addresses go to 0.
REQ-035 rst=1 also clears the accumulators and the latched configuration.
REQ-036 rst asserted mid-job: no further writes after the reset edge; the first start after release runs normally.

Verification
REQ-037 LANES=4, INT8, M=K=2, N=4, A=[[1,2],[3,4]], B=[[5,6,7,8],[1,1,1,1]], acc_mode=0 -> C=[[7,8,9,10],[19,22,25,28]]; done at cycle 2+2*1*5=12.
REQ-038 Same job rerun with acc_mode=1 and C preloaded with the first result -> C=[[14,16,18,20],[38,44,50,56]].
REQ-039 INT8, N=5, LANES=4 -> second pass writes only lane 0 (c_we=0001); the word at i*5+5 is never written by row i.
REQ-040 INT8 with A word 0x000000FF and B word 0x00000002, K=1 -> C=-2 (0xFFFFFFFE); INT16 with the same words -> 510.
REQ-041 K=0, or prec=11 -> done with err=1 two cycles after start; c_we never asserted.
REQ-042 Abort asserted during MAC of pass 2 -> busy=0 next cycle, pass 2 is never written, no done; a following start completes correctly.
